// File: rtl/ipml_sync_fifo_v2_0_fft_fifo.sv
// Single-clock FIFO for the FFT datapath: occupancy-counter flags, sticky error flags,
// and an optional first-word-fall-through output stage.
module ipml_sync_fifo_v2_0_fft_fifo #(
   parameter int c_DATA_WIDTH       = 32,
   parameter int c_DEPTH_WIDTH      = 10,
   parameter int c_FWFT             = 0,
   parameter int c_ALMOST_FULL_NUM  = 1020,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [c_DATA_WIDTH-1:0] wr_data,
   input  logic                    wr_en,
   output logic                    wr_full,
   output logic                    almost_full,
   output logic                    overflow,
   input  logic                    rd_en,
   output logic [c_DATA_WIDTH-1:0] rd_data,
   output logic                    rd_empty,
   output logic                    almost_empty,
   output logic                    underflow,
   input  logic                    err_clr,
   output logic [c_DEPTH_WIDTH:0]  water_level
);

   localparam int                      lp_DEPTH   = 1 << c_DEPTH_WIDTH;
   localparam logic [c_DEPTH_WIDTH:0]  lp_FULL    = (c_DEPTH_WIDTH+1)'(lp_DEPTH);
   localparam logic [c_DEPTH_WIDTH:0]  lp_AF      = (c_DEPTH_WIDTH+1)'(c_ALMOST_FULL_NUM);
   localparam logic [c_DEPTH_WIDTH:0]  lp_AE      = (c_DEPTH_WIDTH+1)'(c_ALMOST_EMPTY_NUM);
   localparam logic [c_DEPTH_WIDTH:0]  lp_LVL_ONE = (c_DEPTH_WIDTH+1)'(1);
   localparam logic [c_DEPTH_WIDTH-1:0] lp_PTR_ONE = c_DEPTH_WIDTH'(1);

   logic [c_DATA_WIDTH-1:0]  r_mem [lp_DEPTH];
   logic [c_DEPTH_WIDTH-1:0] r_wrPtr;
   logic [c_DEPTH_WIDTH-1:0] r_rdPtr;
   logic [c_DEPTH_WIDTH:0]   r_level;
   logic [c_DATA_WIDTH-1:0]  r_rdData;
   logic                     r_outValid;
   logic                     r_full;
   logic                     r_almostFull;
   logic                     r_empty;
   logic                     r_almostEmpty;
   logic                     r_overflow;
   logic                     r_underflow;

   logic                     w_wrAcc;
   logic                     w_rdAcc;
   logic                     w_ramRd;
   logic                     w_nextOutValid;
   logic                     w_nextEmpty;
   logic [c_DEPTH_WIDTH:0]   w_nextLevel;
   logic [c_DEPTH_WIDTH:0]   w_ramCount;

   // In FWFT mode the read-data register doubles as the output stage, so a prefetch
   // fires whenever the stage is empty or being popped and the RAM still holds words.
   always_comb begin
      w_wrAcc        = wr_en && !r_full;
      w_rdAcc        = rd_en && !r_empty;
      w_nextLevel    = r_level;
      w_ramCount     = r_level - {{c_DEPTH_WIDTH{1'b0}}, r_outValid};
      w_ramRd        = 1'b0;
      w_nextOutValid = 1'b0;
      w_nextEmpty    = 1'b1;
      if (w_wrAcc && !w_rdAcc) begin
         w_nextLevel = r_level + lp_LVL_ONE;
      end else if (!w_wrAcc && w_rdAcc) begin
         w_nextLevel = r_level - lp_LVL_ONE;
      end
      if (c_FWFT != 0) begin
         w_ramRd        = (w_ramCount != '0) && (!r_outValid || w_rdAcc);
         w_nextOutValid = w_ramRd || (r_outValid && !w_rdAcc);
         w_nextEmpty    = !w_nextOutValid;
      end else begin
         w_ramRd        = w_rdAcc;
         w_nextEmpty    = (w_nextLevel == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wrAcc) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdData <= '0;
      end else if (w_ramRd) begin
         r_rdData <= r_mem[r_rdPtr];
      end
   end

   // Flags are registered from the next occupancy so they always agree with water_level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_level       <= '0;
         r_outValid    <= 1'b0;
         r_full        <= 1'b0;
         r_almostFull  <= 1'b0;
         r_empty       <= 1'b1;
         r_almostEmpty <= 1'b1;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         if (w_wrAcc) begin
            r_wrPtr <= r_wrPtr + lp_PTR_ONE;
         end
         if (w_ramRd) begin
            r_rdPtr <= r_rdPtr + lp_PTR_ONE;
         end
         r_level       <= w_nextLevel;
         r_outValid    <= w_nextOutValid;
         r_full        <= (w_nextLevel == lp_FULL);
         r_almostFull  <= (w_nextLevel >= lp_AF);
         r_empty       <= w_nextEmpty;
         r_almostEmpty <= (w_nextLevel <= lp_AE);
         if (wr_en && r_full) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (rd_en && r_empty) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign wr_full      = r_full;
   assign almost_full  = r_almostFull;
   assign overflow     = r_overflow;
   assign rd_data      = r_rdData;
   assign rd_empty     = r_empty;
   assign almost_empty = r_almostEmpty;
   assign underflow    = r_underflow;
   assign water_level  = r_level;

endmodule

// File: tb/tb_ipml_sync_fifo_v2_0_fft_fifo.sv
// Directed bench for the FFT FIFO: one standard-mode and one FWFT instance (D=16),
// each checked every cycle against a queue-based scoreboard.
module tb_ipml_sync_fifo_v2_0_fft_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] sWrData = '0;
   logic       sWrEn = 1'b0, sRdEn = 1'b0, sErrClr = 1'b0;
   logic       sFull, sAF, sOvf, sEmpty, sAE, sUdf;
   logic [7:0] sRdData;
   logic [4:0] sLevel;

   logic [7:0] fWrData = '0;
   logic       fWrEn = 1'b0, fRdEn = 1'b0, fErrClr = 1'b0;
   logic       fFull, fAF, fOvf, fEmpty, fAE, fUdf;
   logic [7:0] fRdData;
   logic [4:0] fLevel;

   int         errors = 0;
   int         checks = 0;

   logic [7:0] sQ[$];
   logic [7:0] fQ[$];
   logic [7:0] sRdM = '0;
   logic       sOvfM = 1'b0, sUdfM = 1'b0;
   logic       fOvfM = 1'b0, fUdfM = 1'b0, fValidM = 1'b0;

   ipml_sync_fifo_v2_0_fft_fifo #(
      .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(0),
      .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
   ) uStd (
      .clk(clk), .rst(rst), .wr_data(sWrData), .wr_en(sWrEn), .wr_full(sFull),
      .almost_full(sAF), .overflow(sOvf), .rd_en(sRdEn), .rd_data(sRdData),
      .rd_empty(sEmpty), .almost_empty(sAE), .underflow(sUdf), .err_clr(sErrClr),
      .water_level(sLevel)
   );

   ipml_sync_fifo_v2_0_fft_fifo #(
      .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(1),
      .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
   ) uFwft (
      .clk(clk), .rst(rst), .wr_data(fWrData), .wr_en(fWrEn), .wr_full(fFull),
      .almost_full(fAF), .overflow(fOvf), .rd_en(fRdEn), .rd_data(fRdData),
      .rd_empty(fEmpty), .almost_empty(fAE), .underflow(fUdf), .err_clr(fErrClr),
      .water_level(fLevel)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".s.full"},  32'(sFull),   32'(0));
      checkOutput({tag, ".s.af"},    32'(sAF),     32'(0));
      checkOutput({tag, ".s.ovf"},   32'(sOvf),    32'(0));
      checkOutput({tag, ".s.data"},  32'(sRdData), 32'(0));
      checkOutput({tag, ".s.empty"}, 32'(sEmpty),  32'(1));
      checkOutput({tag, ".s.ae"},    32'(sAE),     32'(1));
      checkOutput({tag, ".s.udf"},   32'(sUdf),    32'(0));
      checkOutput({tag, ".s.level"}, 32'(sLevel),  32'(0));
      checkOutput({tag, ".f.full"},  32'(fFull),   32'(0));
      checkOutput({tag, ".f.af"},    32'(fAF),     32'(0));
      checkOutput({tag, ".f.ovf"},   32'(fOvf),    32'(0));
      checkOutput({tag, ".f.data"},  32'(fRdData), 32'(0));
      checkOutput({tag, ".f.empty"}, 32'(fEmpty),  32'(1));
      checkOutput({tag, ".f.ae"},    32'(fAE),     32'(1));
      checkOutput({tag, ".f.udf"},   32'(fUdf),    32'(0));
      checkOutput({tag, ".f.level"}, 32'(fLevel),  32'(0));
   endtask

   // Standard mode: a read pops the scoreboard head into the expected read register.
   task automatic applyStimulusStd(input logic wr, input logic [7:0] d, input logic rd,
                                   input logic clr, input string tag);
      logic full, empty, wacc, racc;
      int   lvl;
      full  = (sQ.size() == 16);
      empty = (sQ.size() == 0);
      wacc  = wr && !full;
      racc  = rd && !empty;
      sWrEn = wr; sWrData = d; sRdEn = rd; sErrClr = clr;
      @(posedge clk); #1;
      sWrEn = 1'b0; sRdEn = 1'b0; sErrClr = 1'b0;
      sOvfM = (wr && full)  ? 1'b1 : (clr ? 1'b0 : sOvfM);
      sUdfM = (rd && empty) ? 1'b1 : (clr ? 1'b0 : sUdfM);
      if (racc) sRdM = sQ.pop_front();
      if (wacc) sQ.push_back(d);
      lvl = sQ.size();
      checkOutput({tag, ".level"}, 32'(sLevel),  32'(lvl));
      checkOutput({tag, ".full"},  32'(sFull),   32'(lvl == 16));
      checkOutput({tag, ".empty"}, 32'(sEmpty),  32'(lvl == 0));
      checkOutput({tag, ".af"},    32'(sAF),     32'(lvl >= 14));
      checkOutput({tag, ".ae"},    32'(sAE),     32'(lvl <= 2));
      checkOutput({tag, ".ovf"},   32'(sOvf),    32'(sOvfM));
      checkOutput({tag, ".udf"},   32'(sUdf),    32'(sUdfM));
      checkOutput({tag, ".data"},  32'(sRdData), 32'(sRdM));
   endtask

   // FWFT mode: the head is presented once it was already stored before the edge,
   // i.e. one edge after its write edge; rd_data must then equal the scoreboard head.
   task automatic applyStimulusFwft(input logic wr, input logic [7:0] d, input logic rd,
                                    input logic clr, input string tag);
      logic full, wacc, racc;
      int   lvl;
      full  = (fQ.size() == 16);
      wacc  = wr && !full;
      racc  = rd && fValidM;
      fWrEn = wr; fWrData = d; fRdEn = rd; fErrClr = clr;
      @(posedge clk); #1;
      fWrEn = 1'b0; fRdEn = 1'b0; fErrClr = 1'b0;
      fOvfM = (wr && full)     ? 1'b1 : (clr ? 1'b0 : fOvfM);
      fUdfM = (rd && !fValidM) ? 1'b1 : (clr ? 1'b0 : fUdfM);
      if (racc) void'(fQ.pop_front());
      fValidM = (fQ.size() > 0);
      if (wacc) fQ.push_back(d);
      lvl = fQ.size();
      checkOutput({tag, ".level"}, 32'(fLevel), 32'(lvl));
      checkOutput({tag, ".full"},  32'(fFull),  32'(lvl == 16));
      checkOutput({tag, ".empty"}, 32'(fEmpty), 32'(!fValidM));
      checkOutput({tag, ".af"},    32'(fAF),    32'(lvl >= 14));
      checkOutput({tag, ".ae"},    32'(fAE),    32'(lvl <= 2));
      checkOutput({tag, ".ovf"},   32'(fOvf),   32'(fOvfM));
      checkOutput({tag, ".udf"},   32'(fUdf),   32'(fUdfM));
      if (fValidM) checkOutput({tag, ".data"}, 32'(fRdData), 32'(fQ[0]));
   endtask

   task automatic resetModels();
      sQ.delete(); fQ.delete();
      sRdM = '0; sOvfM = 1'b0; sUdfM = 1'b0;
      fOvfM = 1'b0; fUdfM = 1'b0; fValidM = 1'b0;
   endtask

   initial begin
      #12;
      checkReset("por");
      @(posedge clk); #1;
      rst = 1'b0;

      // Standard mode: fill, overflow on the 17th write, then drain in order.
      for (int i = 0; i < 16; i++) applyStimulusStd(1'b1, 8'(i), 1'b0, 1'b0, "s.fill");
      applyStimulusStd(1'b1, 8'h99, 1'b0, 1'b0, "s.wr17");
      for (int i = 0; i < 16; i++) applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b0, "s.drain");

      // Boundaries and error clearing.
      applyStimulusStd(1'b1, 8'h40, 1'b1, 1'b0, "s.rw0");
      applyStimulusStd(1'b0, 8'h00, 1'b0, 1'b1, "s.clr");
      applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b0, "s.rd1");
      applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b1, "s.setwins");
      applyStimulusStd(1'b0, 8'h00, 1'b0, 1'b1, "s.clr2");
      for (int i = 0; i < 16; i++) applyStimulusStd(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "s.thrup");
      applyStimulusStd(1'b1, 8'hEE, 1'b1, 1'b0, "s.rwD");
      for (int i = 0; i < 15; i++) applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b0, "s.thrdn");

      // Continuous streaming at level 3 across several pointer wraps.
      for (int i = 0; i < 3; i++) applyStimulusStd(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "s.pre");
      for (int i = 0; i < 100; i++) applyStimulusStd(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0, "s.wrap");
      for (int i = 0; i < 3; i++) applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b0, "s.post");

      // FWFT latency: two edges from write to a presented word.
      applyStimulusFwft(1'b1, 8'hA5, 1'b0, 1'b0, "f.wA5");
      applyStimulusFwft(1'b0, 8'h00, 1'b0, 1'b0, "f.lat");
      applyStimulusFwft(1'b0, 8'h00, 1'b1, 1'b0, "f.pop");

      // FWFT fill, simultaneous access at full, back-to-back drain, access at empty.
      for (int i = 0; i < 16; i++) applyStimulusFwft(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "f.fill");
      applyStimulusFwft(1'b1, 8'h77, 1'b1, 1'b0, "f.rwD");
      for (int i = 0; i < 15; i++) applyStimulusFwft(1'b0, 8'h00, 1'b1, 1'b0, "f.drain");
      applyStimulusFwft(1'b1, 8'h5A, 1'b1, 1'b0, "f.rw0");
      applyStimulusFwft(1'b0, 8'h00, 1'b0, 1'b1, "f.clr");
      applyStimulusFwft(1'b0, 8'h00, 1'b1, 1'b0, "f.pop1");

      // FWFT streaming with one pop per cycle.
      for (int i = 0; i < 3; i++) applyStimulusFwft(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, "f.pre");
      for (int i = 0; i < 40; i++) applyStimulusFwft(1'b1, 8'(i * 5 + 1), 1'b1, 1'b0, "f.stream");
      for (int i = 0; i < 3; i++) applyStimulusFwft(1'b0, 8'h00, 1'b1, 1'b0, "f.flush");

      // Asynchronous reset in the middle of FWFT pops at level 7.
      for (int i = 0; i < 10; i++) applyStimulusFwft(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "f.load");
      for (int i = 0; i < 3; i++) applyStimulusFwft(1'b0, 8'h00, 1'b1, 1'b0, "f.pop3");
      fRdEn = 1'b1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checkReset("midrst");
      fRdEn = 1'b0;
      resetModels();
      @(posedge clk); #1;
      rst = 1'b0;

      applyStimulusFwft(1'b1, 8'h3C, 1'b0, 1'b0, "f.after.w");
      applyStimulusFwft(1'b0, 8'h00, 1'b0, 1'b0, "f.after.see");
      applyStimulusStd(1'b1, 8'h3C, 1'b0, 1'b0, "s.after.w");
      applyStimulusStd(1'b0, 8'h00, 1'b1, 1'b0, "s.after.r");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
